// File: rtl/chip_checker_spi_pkg.sv
// Shared definitions for the chip-checker SPI master: register addresses,
// STATUS/CONTROL bit positions and the frame FSM state type.
package chip_checker_spi_pkg;

    localparam logic [2:0] ADDR_RXDATA   = 3'd0;
    localparam logic [2:0] ADDR_TXDATA   = 3'd1;
    localparam logic [2:0] ADDR_STATUS   = 3'd2;
    localparam logic [2:0] ADDR_CONTROL  = 3'd3;
    localparam logic [2:0] ADDR_DIVIDER  = 3'd4;
    localparam logic [2:0] ADDR_SLAVESEL = 3'd5;

    // CONTROL bit positions
    localparam int unsigned CTRL_CPOL     = 0;
    localparam int unsigned CTRL_CPHA     = 1;
    localparam int unsigned CTRL_LSBFIRST = 2;
    localparam int unsigned CTRL_ITRDY    = 3;
    localparam int unsigned CTRL_IRRDY    = 4;
    localparam int unsigned CTRL_ITOE     = 5;
    localparam int unsigned CTRL_IROE     = 6;
    localparam int unsigned CTRL_SSO      = 7;

    // STATUS bit positions
    localparam int unsigned STAT_E    = 0;
    localparam int unsigned STAT_RRDY = 1;
    localparam int unsigned STAT_TRDY = 2;
    localparam int unsigned STAT_TMT  = 3;
    localparam int unsigned STAT_TOE  = 4;
    localparam int unsigned STAT_ROE  = 5;
    localparam int unsigned STAT_BUSY = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL
    } spi_state_t;

endpackage

// File: rtl/chip_checker_sync_fifo.sv
// Synchronous FIFO with full/empty flags derived from an occupancy count.
// A push and a pop in the same cycle are both honoured; a push into a full
// FIFO is accepted only when a pop happens in that same cycle.
// Ports: clk, reset (sync, active-high), push/din, pop/dout (head, valid
// while not empty), full, empty.
module chip_checker_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    import chip_checker_spi_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/chip_checker_spi_master_fifo.sv
// Parametrised SPI master with TX/RX FIFOs on the 16-bit register bus.
// Ports: clk, reset (sync, active-high); register bus spi_select, read_n,
// write_n, mem_addr, data_from_cpu, data_to_cpu (registered); irq
// (registered level); SPI pins MISO, MOSI, SCLK, SS_n.
module chip_checker_spi_master_fifo #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned NUM_SLAVES  = 1,
    parameter logic [15:0] DEFAULT_DIV = 16'd9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_select,
    input  logic                  read_n,
    input  logic                  write_n,
    input  logic [2:0]            mem_addr,
    input  logic [15:0]           data_from_cpu,
    output logic [15:0]           data_to_cpu,
    output logic                  irq,
    input  logic                  MISO,
    output logic                  MOSI,
    output logic                  SCLK,
    output logic [NUM_SLAVES-1:0] SS_n
);
    import chip_checker_spi_pkg::*;

    localparam int unsigned EW = $clog2(2*DATA_WIDTH + 1);
    localparam logic [EW-1:0] EDGES = EW'(2*DATA_WIDTH);

    spi_state_t            state;
    logic [7:0]            ctrl;
    logic [15:0]           divider;
    logic [NUM_SLAVES-1:0] slavesel;
    logic                  toe, roe;

    // Per-frame copies so mid-frame register writes only affect the next frame
    logic                  cpha_l, lsb_l;
    logic [15:0]           div_l;
    logic [NUM_SLAVES-1:0] ss_l;

    logic [15:0]           cnt;
    logic [EW-1:0]         edge_cnt;
    logic [DATA_WIDTH-1:0] tx_sh, rx_sh;

    logic                  rd_en, wr_en, last_tick, idle;
    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_WIDTH-1:0] tx_dout, rx_dout;
    logic                  sclk_edge, leading, do_sample, do_shift;
    logic [6:0]            status;

    assign rd_en     = spi_select & ~read_n;
    assign wr_en     = spi_select & ~write_n;
    assign idle      = (state == ST_IDLE);
    assign last_tick = (cnt == div_l);

    assign tx_push = wr_en & (mem_addr == ADDR_TXDATA);
    assign rx_pop  = rd_en & (mem_addr == ADDR_RXDATA);
    assign tx_pop  = ~tx_empty & (idle | ((state == ST_TRAIL) & last_tick & ctrl[CTRL_SSO]));
    assign rx_push = (state == ST_SHIFT) & last_tick & (edge_cnt == EDGES);

    // SCLK edge k = edge_cnt+1; odd k is the leading edge of a bit cell.
    // With CPHA=1 the first bit is already on MOSI from LEAD entry, so the
    // first leading edge does not shift.
    assign sclk_edge = last_tick & ((state == ST_LEAD) |
                       ((state == ST_SHIFT) & (edge_cnt != EDGES)));
    assign leading   = ~edge_cnt[0];
    assign do_sample = sclk_edge & (leading ^ cpha_l);
    assign do_shift  = sclk_edge & (cpha_l ? (leading & (edge_cnt != '0)) : ~leading);

    assign MOSI = lsb_l ? tx_sh[0] : tx_sh[DATA_WIDTH-1];
    assign SS_n = !idle ? ~ss_l : (ctrl[CTRL_SSO] ? ~slavesel : '1);

    assign status = {~idle, roe, toe, tx_empty & idle, ~tx_full, ~rx_empty, toe | roe};

    chip_checker_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .push(tx_push), .din(data_from_cpu[DATA_WIDTH-1:0]),
        .pop(tx_pop), .dout(tx_dout),
        .full(tx_full), .empty(tx_empty)
    );

    chip_checker_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset),
        .push(rx_push), .din(rx_sh),
        .pop(rx_pop), .dout(rx_dout),
        .full(rx_full), .empty(rx_empty)
    );

    // Register file, overflow flags, read data and interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl        <= '0;
            divider     <= DEFAULT_DIV;
            slavesel    <= NUM_SLAVES'(1);
            toe         <= 1'b0;
            roe         <= 1'b0;
            data_to_cpu <= '0;
            irq         <= 1'b0;
        end else begin
            if (wr_en) begin
                case (mem_addr)
                    ADDR_CONTROL:  ctrl     <= data_from_cpu[7:0];
                    ADDR_DIVIDER:  divider  <= data_from_cpu;
                    ADDR_SLAVESEL: slavesel <= data_from_cpu[NUM_SLAVES-1:0];
                    default: ;
                endcase
            end
            // A new overflow wins over a same-cycle STATUS clear
            toe <= (tx_push & tx_full & ~tx_pop) |
                   (toe & ~(wr_en & (mem_addr == ADDR_STATUS)));
            roe <= (rx_push & rx_full & ~rx_pop) |
                   (roe & ~(wr_en & (mem_addr == ADDR_STATUS)));
            if (rd_en) begin
                case (mem_addr)
                    ADDR_RXDATA:   data_to_cpu <= rx_empty ? '0 : 16'(rx_dout);
                    ADDR_STATUS:   data_to_cpu <= {9'b0, status};
                    ADDR_CONTROL:  data_to_cpu <= {8'b0, ctrl};
                    ADDR_DIVIDER:  data_to_cpu <= divider;
                    ADDR_SLAVESEL: data_to_cpu <= 16'(slavesel);
                    default:       data_to_cpu <= '0;
                endcase
            end
            irq <= (status[STAT_RRDY] & ctrl[CTRL_IRRDY]) |
                   (status[STAT_TRDY] & ctrl[CTRL_ITRDY]) |
                   (status[STAT_TOE]  & ctrl[CTRL_ITOE])  |
                   (status[STAT_ROE]  & ctrl[CTRL_IROE]);
        end
    end

    // Frame FSM, divider counter and shift registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            SCLK     <= 1'b0;
            cpha_l   <= 1'b0;
            lsb_l    <= 1'b0;
            div_l    <= '0;
            ss_l     <= NUM_SLAVES'(1);
        end else begin
            if (do_shift) tx_sh <= lsb_l ? (tx_sh >> 1) : (tx_sh << 1);
            if (do_sample) rx_sh <= lsb_l ? {MISO, rx_sh[DATA_WIDTH-1:1]}
                                          : {rx_sh[DATA_WIDTH-2:0], MISO};
            if (tx_pop) begin
                state    <= ST_LEAD;
                cnt      <= '0;
                edge_cnt <= '0;
                tx_sh    <= tx_dout;
                rx_sh    <= '0;
                SCLK     <= ctrl[CTRL_CPOL];
                cpha_l   <= ctrl[CTRL_CPHA];
                lsb_l    <= ctrl[CTRL_LSBFIRST];
                div_l    <= divider;
                ss_l     <= slavesel;
            end else begin
                case (state)
                    ST_LEAD, ST_SHIFT: begin
                        if (last_tick) begin
                            cnt <= '0;
                            if (sclk_edge) begin
                                SCLK     <= ~SCLK;
                                edge_cnt <= edge_cnt + 1'b1;
                                state    <= ST_SHIFT;
                            end else begin
                                state <= ST_TRAIL;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_TRAIL: begin
                        if (last_tick) state <= ST_IDLE;
                        else           cnt   <= cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
